lwe_encrypt: RTL and testbench

Sequential LWE (Regev) encryption stage that sits directly upstream of the decrypt block and produces the ciphertext vector that block consumes. It streams BIG_N public-key rows, one per handshake. A seeded LFSR picks a random subset of those rows, and the block sums the chosen rows mod CIPHERTEXT_MODULUS. It then adds the encoded message into element 0 and presents the ciphertext with a valid/ready handshake.

---
 rtl/lwe_pkg.sv | 25 ++
 rtl/lwe_lfsr16.sv | 39 +++
 rtl/lwe_encrypt.sv | 152 +++++++++++++++
 tb/tb_lwe_encrypt.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lwe_pkg.sv
// Constants and types shared by the LWE encrypt and decrypt blocks.
// Widths here must agree with the decrypt stage that consumes cipher_text.
package lwe_pkg;

    localparam int LWE_PT_WIDTH   = 6;
    localparam int LWE_PT_MODULUS = 64;
    localparam int LWE_CT_WIDTH   = 10;
    localparam int LWE_CT_MODULUS = 1024;

    typedef logic [LWE_CT_WIDTH-1:0] ct_elem_t;

    // Galois LFSR feedback (x^16 + x^14 + x^13 + x^11 + 1), right-shifting form
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;
    // Bit of the LFSR state that decides whether a row joins the subset sum
    localparam logic [15:0] LFSR_SEL_MASK = 16'h0001;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        ENCODE,
        DONE
    } lwe_state_t;

endpackage

// File: rtl/lwe_lfsr16.sv
// 16-bit Galois LFSR used to choose the public-key row subset.
// A zero seed would lock the register at zero, so it is replaced on load.
module lwe_lfsr16
    import lwe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;
    logic [15:0] feedback;

    assign feedback = lfsr_reg[0] ? LFSR_TAPS : 16'h0000;

    always_comb begin
        lfsr_next = lfsr_reg;
        if (load) begin
            lfsr_next = (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
        end else if (step) begin
            lfsr_next = (lfsr_reg >> 1) ^ feedback;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= 16'h0000;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/lwe_encrypt.sv
// Regev LWE encryption: sums an LFSR-chosen subset of BIG_N public-key rows
// mod 2^CIPHERTEXT_WIDTH, adds the message into element 0, hands off valid/ready.
module lwe_encrypt
    import lwe_pkg::*;
#(
    parameter int PLAINTEXT_MODULUS  = LWE_PT_MODULUS,
    parameter int PLAINTEXT_WIDTH    = LWE_PT_WIDTH,
    parameter int DIMENSION          = 1,
    parameter int CIPHERTEXT_MODULUS = LWE_CT_MODULUS,
    parameter int CIPHERTEXT_WIDTH   = LWE_CT_WIDTH,
    parameter int BIG_N              = 30,
    parameter int MSG_SHIFT          = 0
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [PLAINTEXT_WIDTH-1:0]                  message,
    input  logic [15:0]                                 seed,
    input  logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]    pk_row,
    input  logic                                        pk_valid,
    output logic                                        pk_ready,
    output logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]    cipher_text,
    output logic                                        ct_valid,
    input  logic                                        ct_ready,
    output logic                                        busy
);

    localparam int CNT_W = $clog2(BIG_N + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(BIG_N - 1);
    localparam logic [CIPHERTEXT_WIDTH-1:0] CT_MASK = CIPHERTEXT_WIDTH'(CIPHERTEXT_MODULUS - 1);
    localparam logic [PLAINTEXT_WIDTH-1:0]  PT_MASK = PLAINTEXT_WIDTH'(PLAINTEXT_MODULUS - 1);

    lwe_state_t state_reg, state_next;

    logic [CNT_W-1:0]                              cnt_reg, cnt_next;
    logic [PLAINTEXT_WIDTH-1:0]                    msg_reg, msg_next;
    logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]      acc_reg, acc_next;
    logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]      ct_reg, ct_next;
    logic                                          ct_valid_reg, ct_valid_next;

    logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]      acc_sum;
    logic [DIMENSION:0][CIPHERTEXT_WIDTH-1:0]      ct_enc;
    logic [CIPHERTEXT_WIDTH-1:0]                   enc_msg;
    logic [PLAINTEXT_WIDTH-1:0]                    msg_masked;

    logic        lfsr_load;
    logic        lfsr_step;
    logic [15:0] lfsr_state;
    logic        sel;

    lwe_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed),
        .state (lfsr_state)
    );

    assign sel = |(lfsr_state & LFSR_SEL_MASK);

    assign msg_masked = msg_reg & PT_MASK;
    assign enc_msg    = CIPHERTEXT_WIDTH'({{CIPHERTEXT_WIDTH{1'b0}}, msg_masked} << MSG_SHIFT);

    // Per-element datapath: running subset sum, and the final encode where only
    // element 0 carries the message.
    generate
        for (genvar gi = 0; gi <= DIMENSION; gi++) begin : g_elem
            assign acc_sum[gi] = (acc_reg[gi] + pk_row[gi]) & CT_MASK;
            if (gi == 0) begin : g_msg
                assign ct_enc[gi] = (acc_reg[gi] + enc_msg) & CT_MASK;
            end else begin : g_pass
                assign ct_enc[gi] = acc_reg[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        msg_next      = msg_reg;
        acc_next      = acc_reg;
        ct_next       = ct_reg;
        ct_valid_next = ct_valid_reg;
        lfsr_load     = 1'b0;
        lfsr_step     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    msg_next   = message;
                    cnt_next   = '0;
                    acc_next   = '0;
                    lfsr_load  = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                // The LFSR and counter move only on accepted rows so stalls
                // upstream never change which rows are chosen.
                if (pk_valid) begin
                    lfsr_step = 1'b1;
                    cnt_next  = cnt_reg + 1'b1;
                    if (sel) begin
                        acc_next = acc_sum;
                    end
                    if (cnt_reg == LAST_ROW) begin
                        state_next = ENCODE;
                    end
                end
            end
            ENCODE: begin
                ct_next       = ct_enc;
                ct_valid_next = 1'b1;
                state_next    = DONE;
            end
            DONE: begin
                if (ct_ready) begin
                    ct_valid_next = 1'b0;
                    state_next    = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            msg_reg      <= '0;
            acc_reg      <= '0;
            ct_reg       <= '0;
            ct_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            msg_reg      <= msg_next;
            acc_reg      <= acc_next;
            ct_reg       <= ct_next;
            ct_valid_reg <= ct_valid_next;
        end
    end

    assign pk_ready    = (state_reg == ACCUM);
    assign busy        = (state_reg != IDLE);
    assign cipher_text = ct_reg;
    assign ct_valid    = ct_valid_reg;

endmodule

// File: tb/tb_lwe_encrypt.sv
// Scoreboard bench for lwe_encrypt with BIG_N=4: stimulus pushes expected
// ciphertexts, a negedge monitor pops and compares on every ct transfer.
module tb_lwe_encrypt;

    localparam int W  = 10;
    localparam int PW = 6;
    localparam int D  = 1;
    localparam int N  = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [PW-1:0]        message;
    logic [15:0]          seed;
    logic [D:0][W-1:0]    pk_row;
    logic                 pk_valid;
    logic                 pk_ready;
    logic [D:0][W-1:0]    cipher_text;
    logic                 ct_valid;
    logic                 ct_ready;
    logic                 busy;

    lwe_encrypt #(
        .PLAINTEXT_MODULUS  (64),
        .PLAINTEXT_WIDTH    (PW),
        .DIMENSION          (D),
        .CIPHERTEXT_MODULUS (1024),
        .CIPHERTEXT_WIDTH   (W),
        .BIG_N              (N),
        .MSG_SHIFT          (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .message     (message),
        .seed        (seed),
        .pk_row      (pk_row),
        .pk_valid    (pk_valid),
        .pk_ready    (pk_ready),
        .cipher_text (cipher_text),
        .ct_valid    (ct_valid),
        .ct_ready    (ct_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    e0;
        int    e1;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc       = 0;
    int   start_cyc = 0;

    logic [W-1:0] ra [N];
    logic [W-1:0] rb [N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total_cnt++;
        if (act == req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: one comparison pair per accepted ciphertext transfer.
    always @(negedge clk) begin
        if (!rst && ct_valid && ct_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_ct actual=(%0d,%0d) required=none",
                         cipher_text[0], cipher_text[1]);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_ct0"}, int'(cipher_text[0]), e.e0);
                check({e.tag, "_ct1"}, int'(cipher_text[1]), e.e1);
                $display("ct transfer %s: (%0d,%0d) expected (%0d,%0d)",
                         e.tag, cipher_text[0], cipher_text[1], e.e0, e.e1);
            end
        end
    end

    task automatic push_exp(input string tag, input int e0, input int e1);
        exp_t e;
        e.e0 = e0;
        e.e1 = e1;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic set_rows(input int a0, b0, a1, b1, a2, b2, a3, b3);
        ra[0] = W'(a0); rb[0] = W'(b0);
        ra[1] = W'(a1); rb[1] = W'(b1);
        ra[2] = W'(a2); rb[2] = W'(b2);
        ra[3] = W'(a3); rb[3] = W'(b3);
    endtask

    // Called aligned at posedge+1; row 0 is presented together with start.
    task automatic start_enc(input logic [15:0] s, input logic [PW-1:0] m);
        start     = 1'b1;
        seed      = s;
        message   = m;
        pk_row[0] = ra[0];
        pk_row[1] = rb[0];
        pk_valid  = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        start     = 1'b0;
        seed      = 16'h5A5A;
        message   = PW'(17);
    endtask

    task automatic feed_rows(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            int waited;
            pk_row[0] = ra[i];
            pk_row[1] = rb[i];
            pk_valid  = 1'b1;
            waited    = 0;
            @(negedge clk);
            while (!pk_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!pk_ready) begin
                total_cnt++;
                $display("FAIL row_accept_timeout actual=pk_ready=0 required=pk_ready=1");
            end
            @(posedge clk); #1;
            if (gap > 0 && i < n - 1) begin
                pk_valid  = 1'b0;
                pk_row[0] = W'(999);
                pk_row[1] = W'(999);
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_pk_ready", int'(pk_ready), 1);
                    @(posedge clk); #1;
                end
            end
        end
        pk_valid = 1'b0;
    endtask

    // Returns at the negedge where ct_valid is first seen; lat is edges since start.
    task automatic wait_ct(output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!ct_valid && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ct_valid) begin
            total_cnt++;
            $display("FAIL ct_valid_timeout actual=0 required=1");
        end
        lat = cyc - start_cyc;
    endtask

    task automatic run_enc(input string tag, input logic [15:0] s,
                           input logic [PW-1:0] m, input int e0, input int e1,
                           input int gap, input bit lat_check);
        int lat;
        push_exp(tag, e0, e1);
        start_enc(s, m);
        feed_rows(N, gap);
        wait_ct(lat);
        if (lat_check) check({tag, "_latency_edges"}, lat, N + 1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_ct_valid_drop"}, int'(ct_valid), 0);
        check({tag, "_busy_idle"}, int'(busy), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst      = 1'b1;
        start    = 1'b0;
        message  = '0;
        seed     = '0;
        pk_row   = '0;
        pk_valid = 1'b0;
        ct_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_pk_ready", int'(pk_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ct_valid", int'(ct_valid), 0);
        check("rst_ct0", int'(cipher_text[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Test 1: every row selected, latency checked
        set_rows(1, 2, 3, 4, 5, 6, 7, 8);
        run_enc("t1_all_rows", 16'hFFFF, PW'(5), 21, 20, 0, 1'b1);

        // Test 2: only row 0 selected
        run_enc("t2_row0", 16'h0001, PW'(0), 1, 2, 0, 1'b0);

        // Test 3: modular wrap of both elements
        set_rows(1000, 1023, 1000, 1023, 1000, 1023, 1000, 1023);
        run_enc("t3_wrap", 16'hFFFF, PW'(63), 991, 1020, 0, 1'b0);

        // Test 4: row gaps, then output backpressure with a stray start
        set_rows(1, 2, 3, 4, 5, 6, 7, 8);
        ct_ready = 1'b0;
        push_exp("t4_backpressure", 21, 20);
        start_enc(16'hFFFF, PW'(5));
        feed_rows(N, 3);
        wait_ct(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            start = (k == 1);
            seed  = 16'h0001;
            @(negedge clk);
            check("t4_hold_ct0", int'(cipher_text[0]), 21);
            check("t4_hold_ct1", int'(cipher_text[1]), 20);
            check("t4_hold_pk_ready", int'(pk_ready), 0);
            check("t4_hold_ct_valid", int'(ct_valid), 1);
        end
        @(posedge clk); #1;
        start    = 1'b0;
        ct_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_start_ignored_busy", int'(busy), 0);
        check("t4_ct_valid_drop", int'(ct_valid), 0);
        @(posedge clk); #1;

        // Test 5: asynchronous reset after two accepted rows
        start_enc(16'h0001, PW'(0));
        feed_rows(2, 0);
        check("t5_pre_rst_pk_ready", int'(pk_ready), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_pk_ready", int'(pk_ready), 0);
        check("t5_async_busy", int'(busy), 0);
        check("t5_async_ct_valid", int'(ct_valid), 0);
        check("t5_async_ct0", int'(cipher_text[0]), 0);
        check("t5_async_ct1", int'(cipher_text[1]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_enc("t5_fresh_run", 16'h0001, PW'(0), 1, 2, 0, 1'b0);

        // Test 6: zero seed behaves as seed 1; decrypt loopback with key (1,0)
        run_enc("t6_zero_seed", 16'h0000, PW'(0), 1, 2, 0, 1'b0);
        check("t6_loopback_decrypt",
              int'((cipher_text[0] * 1 + cipher_text[1] * 0) % 64), (1 * 1 + 2 * 0) % 64);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
